// File: rtl/decoder_pkg.sv
// Shared types and widths for the 2-to-4 streaming decoder.
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 4;

  // Occupancy of the output register plus skid register pair
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // One-hot decode of a binary code; a disabled decode yields an all-zero word
  function automatic logic [OUT_W-1:0] decode2x4(input logic [CODE_W-1:0] code,
                                                 input logic              en);
    logic [OUT_W-1:0] result;
    result = '0;
    if (en) begin
      result[code] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/decoder_2x4_core.sv
// Pure combinational 2-to-4 decoder with enable.
module decoder_2x4_core
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              en_i,
  output logic [OUT_W-1:0]  onehot_o
);

  // Decode the incoming code into its one-hot word
  always_comb begin
    onehot_o = decode2x4(code_i, en_i);
  end

endmodule

// File: rtl/decoder_2x4_stream.sv
// Streaming 2-to-4 decoder: valid/ready input, one-cycle latency, output
// register plus one skid register so in_ready never depends on out_ready
// combinationally.
// Optional feature: define DEC_CNT_EN to add the xfer_cnt accepted-input
// counter port (CNT_W bits, wrapping).
module decoder_2x4_stream
  import decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_onehot
`ifdef DEC_CNT_EN
  ,
  output logic [CNT_W-1:0]  xfer_cnt
`endif
);

  state_e            state_q;
  state_e            state_d;
  logic [OUT_W-1:0]  outData_q;
  logic [OUT_W-1:0]  outData_d;
  logic [OUT_W-1:0]  skidData_q;
  logic [OUT_W-1:0]  skidData_d;
  logic              inReady_q;
  logic              inReady_d;
  logic [OUT_W-1:0]  decoded;
  logic              inXfer;
  logic              outXfer;

  decoder_2x4_core u_core (
    .code_i   (in_code),
    .en_i     (in_en),
    .onehot_o (decoded)
  );

  assign inXfer     = in_valid & inReady_q;
  assign outXfer    = out_valid & out_ready;
  assign in_ready   = inReady_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_onehot = out_valid ? outData_q : '0;

  // Next-state and datapath moves for the output/skid register pair
  always_comb begin
    state_d    = state_q;
    outData_d  = outData_q;
    skidData_d = skidData_q;
    case (state_q)
      EMPTY: begin
        if (inXfer) begin
          state_d   = ONE;
          outData_d = decoded;
        end
      end
      ONE: begin
        if (inXfer && outXfer) begin
          outData_d = decoded;
        end else if (inXfer) begin
          state_d    = TWO;
          skidData_d = decoded;
        end else if (outXfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (outXfer) begin
          state_d   = ONE;
          outData_d = skidData_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    inReady_d = (state_d != TWO);
  end

  // State, data and registered ready; reset discards any held codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
      inReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      outData_q  <= outData_d;
      skidData_q <= skidData_d;
      inReady_q  <= inReady_d;
    end
  end

`ifdef DEC_CNT_EN
  logic [CNT_W-1:0] xferCnt_q;

  // Count accepted input codes, wrapping naturally at the counter width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xferCnt_q <= '0;
    end else if (inXfer) begin
      xferCnt_q <= xferCnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt = xferCnt_q;
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_decoder_2x4_stream.sv
// Self-checking bench for decoder_2x4_stream with a scoreboard queue.
// Define DEC_CNT_EN to also exercise the xfer_cnt counter.
module tb_decoder_2x4_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_code = 2'd0;
  logic       in_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_onehot;
`ifdef DEC_CNT_EN
  logic [7:0] xfer_cnt;
`endif

  int         checkCount = 0;
  int         failCount = 0;
  int         pushCount = 0;
  logic [3:0] sbQ[$];
  bit         monEn = 1'b0;
  bit         prevStall = 1'b0;
  logic [3:0] prevData = 4'd0;

  decoder_2x4_stream #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot)
`ifdef DEC_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference decode written as an explicit table
  function automatic logic [3:0] expDecode(input logic [1:0] code, input logic en);
    if (!en) return 4'b0000;
    case (code)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one code and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [1:0] code, input logic en);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    in_en    = en;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  // Asynchronous reset pulse mid-cycle, with immediate output checks
  task automatic doReset();
    monEn = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_onehot", out_onehot, 0);
    checkOutput("rst_in_ready", in_ready, 1);
`ifdef DEC_CNT_EN
    checkOutput("rst_xfer_cnt", xfer_cnt, 0);
`endif
    sbQ.delete();
    prevStall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    monEn = 1'b1;
  endtask

  // Scoreboard monitor: sampled on the falling edge, ahead of the next rising edge
  always @(negedge clk) begin
    if (monEn && rst_n) begin
      checkOutput("in_ready_model", in_ready, (sbQ.size() < 2) ? 1 : 0);
      checkOutput("out_valid_model", out_valid, (sbQ.size() > 0) ? 1 : 0);
      if (!out_valid) checkOutput("idle_zero", out_onehot, 0);
      if (prevStall) checkOutput("hold_data", out_onehot, prevData);
      if (out_valid && out_ready) begin
        if (sbQ.size() > 0) checkOutput("sb_data", out_onehot, sbQ.pop_front());
        else checkOutput("sb_underflow", sbQ.size(), 1);
      end
      if (in_valid && in_ready) begin
        sbQ.push_back(expDecode(in_code, in_en));
        pushCount++;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_onehot;
    end
  end

  // Safety net in case a wait ever goes unbounded
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed and random test sequence
  initial begin
    int startCount;
    doReset();

    // Each code decodes one cycle after acceptance, with ready never dropping
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'(i), 1'b1);
      checkOutput("lat_valid", out_valid, 1);
      checkOutput("lat_onehot", out_onehot, expDecode(2'(i), 1'b1));
      checkOutput("lat_in_ready", in_ready, 1);
    end
    repeat (2) @(posedge clk);
    #1;

    // Disabled decode still transfers, as an all-zero word
    out_ready = 1'b0;
    applyStimulus(2'd2, 1'b0);
    checkOutput("en0_valid", out_valid, 1);
    checkOutput("en0_onehot", out_onehot, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fill both registers, stall, then drain in order
    out_ready = 1'b0;
    applyStimulus(2'd1, 1'b1);
    applyStimulus(2'd3, 1'b1);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_onehot", out_onehot, 4'b0010);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_onehot", out_onehot, 4'b0010);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("drain1_onehot", out_onehot, 4'b1000);
    checkOutput("drain1_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("drain2_valid", out_valid, 0);

    // Reset while full: held codes must never emerge
    out_ready = 1'b0;
    applyStimulus(2'd0, 1'b1);
    applyStimulus(2'd3, 1'b1);
    doReset();
    out_ready = 1'b1;
    applyStimulus(2'd2, 1'b1);
    checkOutput("post_rst_onehot", out_onehot, 4'b0100);
    repeat (2) @(posedge clk);
    #1;

`ifdef DEC_CNT_EN
    // Counter wraps after 256 transfers
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) applyStimulus(2'($urandom), 1'b1);
    checkOutput("cnt_wrap", xfer_cnt, 1);
    repeat (2) @(posedge clk);
    #1;
`endif

    // Random valid/ready traffic checked by the scoreboard
    startCount = pushCount;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      if (pushCount - startCount >= 1000) break;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 1) != 0);
      in_code   = 2'($urandom);
      in_en     = ($urandom_range(0, 7) != 0);
    end
    in_valid = 1'b0;
    checkOutput("rand_count", pushCount - startCount, 1000);

    // Drain everything still held
    out_ready = 1'b1;
    for (int c = 0; c < 50 && sbQ.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checkOutput("final_sb_empty", sbQ.size(), 0);
    checkOutput("final_out_valid", out_valid, 0);

    monEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/decoder_2x4_stream.md
DECODER_2X4_STREAM -- requirements
Module: decoder_2x4_stream

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Parameter: CNT_W, 8, width of the transfer counter.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  upstream code valid.
REQ-006 Port: in_ready  output  1  block can accept a code.
REQ-007 Port: in_code  input  2  binary code to decode.
REQ-008 Port: in_en  input  1  decode enable, sampled with the code.
REQ-009 Port: out_valid  output  1  one-hot result valid.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: out_onehot  output  4  decoded one-hot word.
REQ-012 Port: xfer_cnt  output  CNT_W  accepted-input count (only with DEC_CNT_EN).

Function
REQ-013 Input transfer SHALL occur on a rising clk edge where in_valid and in_ready are both 1; output transfer, where out_valid and out_ready are both 1.
REQ-014 Decode: in_en=1 -> out_onehot = 1 << in_code (00->0001, 01->0010, 10->0100, 11->1000); in_en=0 -> 0000, still a transfer.
REQ-015 Latency SHALL be one cycle: a code accepted at edge N appears on out_onehot with out_valid=1 after edge N when the output register was empty or drained at N.
REQ-016 Storage SHALL be an output register plus one skid register; states EMPTY, ONE, TWO.
REQ-017 EMPTY: input transfer -> ONE; else stay.
REQ-018 ONE: input only -> TWO (code into skid); output only -> EMPTY; both -> ONE with new value in output register; neither -> stay.
REQ-019 TWO: output transfer -> ONE (skid moves to output register); else stay; no input transfer possible.
REQ-020 in_ready SHALL be registered, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-021 out_valid SHALL be 1 in ONE and TWO; out_onehot SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Order SHALL be preserved; no code dropped or duplicated.
REQ-023 out_onehot SHALL be 0000 whenever out_valid=0.

Reset
REQ-024 rst_n low SHALL immediately force state EMPTY, out_valid=0, out_onehot=0000, in_ready=1, xfer_cnt=0, including mid-operation with data held; held data is discarded.
REQ-025 First transfer SHALL be possible on the first edge after rst_n deasserts.

Configuration
REQ-026 Macro DEC_CNT_EN defined: xfer_cnt increments by 1 per input transfer, wraps from 2^CNT_W-1 to 0.
REQ-027 DEC_CNT_EN undefined: xfer_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-028 Package decoder_pkg SHALL hold the state enum (EMPTY/ONE/TWO), CODE_W=2, OUT_W=4.
REQ-029 Sub-module decoder_2x4_core (pure combinational code+enable -> one-hot) SHALL be instantiated once at the input side.

Verification
REQ-030 Reset then codes 00,01,10,11 with out_ready=1 -> out_onehot 0001,0010,0100,1000 one cycle after each, in_ready stays 1.
REQ-031 in_en=0 with code 10 -> out_valid=1, out_onehot=0000.
REQ-032 out_ready=0, send 01 then 11 -> in_ready=0 after second; raise out_ready -> 0010 then 1000, in_ready back to 1.
REQ-033 Stall in TWO, pulse rst_n low -> out_valid=0, out_onehot=0000, in_ready=1 asynchronously; held codes never appear.
REQ-034 DEC_CNT_EN, CNT_W=8, 257 transfers -> xfer_cnt=1.
REQ-035 Random valid/ready, 1000 codes -> output sequence equals input decode sequence.
